// File: rtl/btn_switch_reader.sv
// btn_switch_reader
//   Reads push-buttons and DIP switches. Each input passes through a 2-flop
//   synchroniser, then a time-based debounce, then press/release edge
//   detection. Debounced levels are exported directly. Edges are delivered
//   one at a time on a valid/ready event stream, lowest index first.
//
// Ports
//   clk_i        system clock (CLK_IN_MHZ MHz)
//   rst_i        synchronous, active-high reset
//   raw_i        asynchronous button/switch pins
//   level_o      debounced level per input, 1 = active
//   evt_valid_o  event available
//   evt_ready_i  consumer accepts the presented event
//   evt_idx_o    index of the input that changed
//   evt_press_o  1 = became active, 0 = became inactive
//   ovf_o        sticky: an edge was lost because its input already had an
//                unconsumed event
module btn_switch_reader #(
  parameter int   NUM_INPUTS     = 8,
  parameter int   CLK_IN_MHZ     = 125,
  parameter int   DEBOUNCE_US    = 10000,
  parameter logic INPUT_POLARITY = 1'b0,
  localparam int  IDX_W          = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_INPUTS-1:0] raw_i,
  output logic [NUM_INPUTS-1:0] level_o,
  output logic                  evt_valid_o,
  input  logic                  evt_ready_i,
  output logic [IDX_W-1:0]      evt_idx_o,
  output logic                  evt_press_o,
  output logic                  ovf_o
);

  localparam int PW = (CLK_IN_MHZ > 1) ? $clog2(CLK_IN_MHZ) : 1;
  localparam int CW = $clog2(DEBOUNCE_US + 1);

  localparam logic [NUM_INPUTS-1:0] IDLE_RAW = {NUM_INPUTS{~INPUT_POLARITY}};
  localparam logic [NUM_INPUTS-1:0] POL_VEC  = {NUM_INPUTS{INPUT_POLARITY}};

  logic [NUM_INPUTS-1:0] sync1;
  logic [NUM_INPUTS-1:0] sync2;
  logic [NUM_INPUTS-1:0] act_s;
  logic [PW-1:0]         presc;
  logic                  tick;
  logic [CW-1:0]         cnt [NUM_INPUTS];
  logic [NUM_INPUTS-1:0] toggle;
  logic [NUM_INPUTS-1:0] toggle_q;
  logic [NUM_INPUTS-1:0] level_nxt;
  logic [NUM_INPUTS-1:0] pend;
  logic [NUM_INPUTS-1:0] pend_nxt;
  logic [NUM_INPUTS-1:0] clr_vec;
  logic                  load;
  logic                  sel_found;
  logic [IDX_W-1:0]      sel_idx;
  logic                  sel_press;
  logic                  ovf_set;

  // Synchroniser; idle level on reset so no spurious edge follows release.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1 <= IDLE_RAW;
      sync2 <= IDLE_RAW;
    end else begin
      sync1 <= raw_i;
      sync2 <= sync1;
    end
  end

  assign act_s = ~(sync2 ^ POL_VEC);

  // Shared 1 us prescaler.
  assign tick = (presc == PW'(CLK_IN_MHZ - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // A level change is accepted on the tick that completes DEBOUNCE_US
  // consecutive microseconds of disagreement.
  always_comb begin
    toggle = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      toggle[i] = (act_s[i] != level_o[i]) && tick &&
                  (cnt[i] == CW'(DEBOUNCE_US - 1));
    end
  end

  assign level_nxt = level_o ^ toggle;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        cnt[i] <= '0;
      end
      level_o  <= '0;
      toggle_q <= '0;
    end else begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (act_s[i] == level_o[i]) begin
          cnt[i] <= '0;
        end else if (tick) begin
          if (toggle[i]) begin
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + CW'(1);
          end
        end
      end
      level_o  <= level_nxt;
      toggle_q <= toggle;
    end
  end

  // Lowest-index pending selection. The reported polarity uses level_nxt so
  // a second toggle landing in the load cycle reports the newest level.
  assign load = !evt_valid_o || evt_ready_i;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_press = 1'b0;
    clr_vec   = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (pend[i] && !sel_found) begin
        sel_found  = 1'b1;
        sel_idx    = IDX_W'(i);
        sel_press  = level_nxt[i];
        clr_vec[i] = load;
      end
    end
  end

  // Set wins over clear; a set on a still-pending bit loses an edge.
  assign pend_nxt = (pend & ~clr_vec) | toggle_q;
  assign ovf_set  = |(toggle_q & pend & ~clr_vec);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend        <= '0;
      evt_valid_o <= 1'b0;
      evt_idx_o   <= '0;
      evt_press_o <= 1'b0;
      ovf_o       <= 1'b0;
    end else begin
      pend <= pend_nxt;
      if (ovf_set) begin
        ovf_o <= 1'b1;
      end
      if (load) begin
        evt_valid_o <= sel_found;
        if (sel_found) begin
          evt_idx_o   <= sel_idx;
          evt_press_o <= sel_press;
        end
      end
    end
  end

endmodule
